// File: rtl/tinyalu_gen_pkg.sv
// Shared opcode/state types for the tinyalu_gen datapath.
package tinyalu_gen_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_AND = 3'd2,
    OP_XOR = 3'd3,
    OP_MUL = 3'd4,
    OP_SUB = 3'd5,
    OP_MAC = 3'd6,
    OP_CLR = 3'd7
  } op_e;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_WAIT = 1'b1
  } state_e;

  function automatic logic is_multicycle(input op_e op);
    return (op == OP_MUL) || (op == OP_MAC);
  endfunction

endpackage

// File: rtl/tinyalu_gen_mul_pipe.sv
// Registered W x W multiplier; the top's result register is the final stage,
// so this block holds MUL_LAT-1 stages with a matching valid shift register.
module tinyalu_gen_mul_pipe #(
  parameter int W       = 8,
  parameter int MUL_LAT = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           out_valid_o,
  output logic [2*W-1:0] product_o
);

  localparam int N = MUL_LAT - 1;

  logic [N-1:0]   vld_q;
  logic [2*W-1:0] prod_q [N];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q[0] <= 1'b0;
    end else begin
      vld_q[0] <= in_valid_i;
    end
    if (in_valid_i) begin
      prod_q[0] <= {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
    end
  end

  for (genvar gi = 1; gi < N; gi++) begin : g_stage
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_q[gi] <= 1'b0;
      end else begin
        vld_q[gi] <= vld_q[gi-1];
      end
      prod_q[gi] <= prod_q[gi-1];
    end
  end

  assign out_valid_o = vld_q[N-1];
  assign product_o   = prod_q[N-1];

endmodule

// File: rtl/tinyalu_gen.sv
// Parametrised ALU with start/done handshake, pipelined MUL/MAC and a sticky-overflow
// accumulator. Define TINYALU_GEN_STATUS_EN to add the status[1:0] = {carry, zero} output.
module tinyalu_gen
  import tinyalu_gen_pkg::*;
#(
  parameter int W       = 8,
  parameter int MUL_LAT = 3,
  parameter int ACC_W   = 2*W+8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2:0]     op,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic           done,
  output logic           busy,
  output logic [2*W-1:0] result,
  output logic           acc_ovf
`ifdef TINYALU_GEN_STATUS_EN
  ,
  output logic [1:0]     status
`endif
);

  localparam int R = 2*W;

  state_e           state_q;
  logic             done_q;
  logic [R-1:0]     result_q;
  logic [ACC_W-1:0] acc_q;
  logic             acc_ovf_q;
  logic             mac_q;

  op_e              op_in;
  logic [R-1:0]     a_ext, b_ext;
  logic [R-1:0]     alu_res_d;
  logic             alu_carry_d;
  logic             accept;
  logic             pipe_vld;
  logic [R-1:0]     pipe_prod;
  logic [ACC_W:0]   acc_sum_d;

  assign op_in  = op_e'(op);
  assign a_ext  = {{W{1'b0}}, A};
  assign b_ext  = {{W{1'b0}}, B};
  assign accept = start && (state_q == IDLE);

  always_comb begin
    alu_res_d   = '0;
    alu_carry_d = 1'b0;
    case (op_in)
      OP_ADD: begin
        alu_res_d   = a_ext + b_ext;
        alu_carry_d = alu_res_d[W];
      end
      OP_SUB: begin
        alu_res_d   = a_ext - b_ext;
        alu_carry_d = (A < B);
      end
      OP_AND:  alu_res_d = a_ext & b_ext;
      OP_XOR:  alu_res_d = a_ext ^ b_ext;
      default: alu_res_d = '0;
    endcase
  end

  // Extra top bit captures the carry out of the accumulator for acc_ovf.
  assign acc_sum_d = {1'b0, acc_q} + {{(ACC_W-R+1){1'b0}}, pipe_prod};

  tinyalu_gen_mul_pipe #(
    .W       (W),
    .MUL_LAT (MUL_LAT)
  ) u_mul_pipe (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (accept && is_multicycle(op_in)),
    .a_i         (A),
    .b_i         (B),
    .out_valid_o (pipe_vld),
    .product_o   (pipe_prod)
  );

`ifdef TINYALU_GEN_STATUS_EN
  logic [1:0] status_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      result_q  <= '0;
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
      mac_q     <= 1'b0;
`ifdef TINYALU_GEN_STATUS_EN
      status_q  <= 2'b00;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            case (op_in)
              OP_NOP: ;
              OP_MUL, OP_MAC: begin
                state_q <= MUL_WAIT;
                mac_q   <= (op_in == OP_MAC);
              end
              OP_CLR: begin
                acc_q     <= '0;
                acc_ovf_q <= 1'b0;
                result_q  <= '0;
                done_q    <= 1'b1;
`ifdef TINYALU_GEN_STATUS_EN
                status_q  <= 2'b01;
`endif
              end
              default: begin
                result_q <= alu_res_d;
                done_q   <= 1'b1;
`ifdef TINYALU_GEN_STATUS_EN
                status_q <= {alu_carry_d, (alu_res_d == '0)};
`endif
              end
            endcase
          end
        end
        MUL_WAIT: begin
          if (pipe_vld) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            if (mac_q) begin
              acc_q     <= acc_sum_d[ACC_W-1:0];
              acc_ovf_q <= acc_ovf_q | acc_sum_d[ACC_W];
              result_q  <= acc_sum_d[R-1:0];
`ifdef TINYALU_GEN_STATUS_EN
              status_q  <= {1'b0, (acc_sum_d[R-1:0] == '0)};
`endif
            end else begin
              result_q  <= pipe_prod;
`ifdef TINYALU_GEN_STATUS_EN
              status_q  <= {1'b0, (pipe_prod == '0)};
`endif
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done    = done_q;
  assign busy    = (state_q == MUL_WAIT);
  assign result  = result_q;
  assign acc_ovf = acc_ovf_q;
`ifdef TINYALU_GEN_STATUS_EN
  assign status  = status_q;
`endif

endmodule

// File: tb/tb_tinyalu_gen.sv
// Directed scoreboard bench for tinyalu_gen (W=8, MUL_LAT=3, ACC_W=24).
module tb_tinyalu_gen;

  localparam logic [2:0] OP_NOP = 3'd0, OP_ADD = 3'd1, OP_AND = 3'd2, OP_XOR = 3'd3,
                         OP_MUL = 3'd4, OP_SUB = 3'd5, OP_MAC = 3'd6, OP_CLR = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = OP_NOP;
  logic [7:0]  A = '0, B = '0;
  logic        done, busy, acc_ovf;
  logic [15:0] result;
`ifdef TINYALU_GEN_STATUS_EN
  logic [1:0]  status;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q [$];
  logic [23:0] acc_m = '0;
  logic        ovf_m = 1'b0;

  tinyalu_gen #(.W(8), .MUL_LAT(3), .ACC_W(24)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .A       (A),
    .B       (B),
    .done    (done),
    .busy    (busy),
    .result  (result),
    .acc_ovf (acc_ovf)
`ifdef TINYALU_GEN_STATUS_EN
    ,
    .status  (status)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  // Scoreboard: every done pops the oldest expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(result), 32'hDEAD_BEEF);
      end else begin
        chk("result", 32'(result), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic single(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] expv, input string tag);
    op = o; A = a; B = b; start = 1'b1;
    exp_q.push_back(expv);
    @(negedge clk);
    chk({tag, "_done"}, 32'(done), 32'd1);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic mac(input logic [7:0] a, input logic [7:0] b, input string tag);
    logic [24:0] s;
    s = {1'b0, acc_m} + 25'(a * b);
    ovf_m = ovf_m | s[24];
    acc_m = s[23:0];
    op = OP_MAC; A = a; B = b; start = 1'b1;
    exp_q.push_back(acc_m[15:0]);
    @(negedge clk);
    start = 1'b0;
    wait_drain(8);
    chk({tag, "_ovf"}, 32'(acc_ovf), 32'(ovf_m));
  endtask

  initial begin
    repeat (10) @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_ovf", 32'(acc_ovf), 32'd0);
    reset = 1'b0;

    // Back-to-back ADD stream.
    op = OP_ADD; start = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      A = 8'(k % 200); B = 8'(k % 200);
      exp_q.push_back(16'(2 * (k % 200)));
      @(negedge clk);
      chk("add_stream_done", 32'(done), 32'd1);
    end
    start = 1'b0;
    @(negedge clk);
    chk("add_stream_end", 32'(done), 32'd0);
    wait_drain(4);

    // MUL latency, busy window, and dropped start while busy.
    op = OP_MUL; A = 8'd255; B = 8'd255; start = 1'b1;
    exp_q.push_back(16'hFE01);
    @(negedge clk);
    chk("mul_busy1", 32'(busy), 32'd1);
    chk("mul_nodone1", 32'(done), 32'd0);
    op = OP_ADD; A = 8'd1; B = 8'd1;
    @(negedge clk);
    chk("mul_busy2", 32'(busy), 32'd1);
    chk("mul_nodone2", 32'(done), 32'd0);
    start = 1'b0;
    @(negedge clk);
    chk("mul_done", 32'(done), 32'd1);
    chk("mul_busy_clr", 32'(busy), 32'd0);
    @(negedge clk);
    chk("mul_no_extra", 32'(done), 32'd0);
    wait_drain(4);

    single(OP_SUB, 8'd1, 8'd2, 16'hFFFF, "sub_neg");
`ifdef TINYALU_GEN_STATUS_EN
    chk("sub_neg_status", 32'(status), 32'b10);
`endif
    single(OP_SUB, 8'd5, 8'd5, 16'h0000, "sub_zero");
`ifdef TINYALU_GEN_STATUS_EN
    chk("sub_zero_status", 32'(status), 32'b01);
`endif
    single(OP_ADD, 8'd255, 8'd255, 16'h01FE, "add_carry");
`ifdef TINYALU_GEN_STATUS_EN
    chk("add_carry_status", 32'(status), 32'b10);
`endif
    single(OP_AND, 8'hF0, 8'h3C, 16'h0030, "and");
    single(OP_XOR, 8'hFF, 8'h0F, 16'h00F0, "xor");
    wait_drain(4);

    // MAC until the 24-bit accumulator wraps, then a few more to show stickiness.
    for (int i = 0; i < 260; i++) mac(8'd255, 8'd255, "mac");
    chk("mac_sticky", 32'(acc_ovf), 32'd1);
    single(OP_CLR, 8'd9, 8'd9, 16'h0000, "clr");
    acc_m = '0; ovf_m = 1'b0;
    chk("clr_ovf", 32'(acc_ovf), 32'd0);
    mac(8'd2, 8'd3, "mac_after_clr");

    // Reset one cycle after a MUL accept aborts it silently.
    op = OP_MUL; A = 8'd10; B = 8'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_quiet", 32'(done), 32'd0);
    end
    single(OP_ADD, 8'd3, 8'd4, 16'd7, "add_after_abort");
    wait_drain(4);

    // NOP with start held: no done, result held.
    op = OP_NOP; A = 8'd1; B = 8'd1; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("nop_done", 32'(done), 32'd0);
      chk("nop_hold", 32'(result), 32'd7);
    end
    start = 1'b0;
    @(negedge clk);
    wait_drain(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
